// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Arbitrates the local bus between the 68000 and a Zorro II DMA master
//   (A590/GVP style). The DMA request, the grant acknowledge and the CPU
//   bus grant are all asynchronous, so each one passes through a two-flop
//   synchroniser before the FSM uses it. All outputs are registered.
//
//   Optional feature: define ARB_GRANT_TIMEOUT_EN to enable the grant
//   watchdog. The watchdog abandons a grant that has not been
//   acknowledged after 16 cycles. The default build has no watchdog, and
//   in that build GRANT waits indefinitely.
//
// Ports
//   C7M         in   sole clock, rising edge
//   RESET_n     in   synchronous active-low reset
//   BR_MB_n     in   bus request from DMA master (async)
//   BGACK_MB_n  in   bus-grant-acknowledge from DMA master (async)
//   BG_CPU_n    in   bus grant from 68000 (async)
//   AS_CPU_n    in   CPU address strobe
//   BR_CPU_n    out  bus request to 68000
//   BG_MB_n     out  bus grant to DMA master
//   CPU_OWNER   out  high while the CPU owns the bus
//   DMA_ACTIVE  out  high while the DMA master owns the bus
//
// state   | meaning
// IDLE    | CPU owns bus, no request pending
// REQ     | requesting bus from CPU, waiting for BG
// GRANT   | grant passed to DMA master, waiting for BGACK and end of CPU cycle
// DMA     | DMA master owns the bus
// RELEASE | single handover cycle back to CPU
// BACKOFF | grant abandoned, waiting for request to drop
module bus_arbiter (
  input  logic C7M,
  input  logic RESET_n,
  input  logic BR_MB_n,
  input  logic BGACK_MB_n,
  input  logic BG_CPU_n,
  input  logic AS_CPU_n,
  output logic BR_CPU_n,
  output logic BG_MB_n,
  output logic CPU_OWNER,
  output logic DMA_ACTIVE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_GRANT   = 3'd2,
    S_DMA     = 3'd3,
    S_RELEASE = 3'd4,
    S_BACKOFF = 3'd5
  } state_t;

  state_t r_state;

  logic r_br_meta, r_br_s;
  logic r_bgack_meta, r_bgack_s;
  logic r_bg_meta, r_bg_s;

`ifdef ARB_GRANT_TIMEOUT_EN
  logic [3:0] r_grant_cnt;
`endif

  // Synchronisers reset to the inactive level (1). After reset, a request
  // therefore needs two fresh samples of BR_MB_n before IDLE can act on it.
  always_ff @(posedge C7M) begin
    if (!RESET_n) begin
      r_br_meta    <= 1'b1;
      r_br_s       <= 1'b1;
      r_bgack_meta <= 1'b1;
      r_bgack_s    <= 1'b1;
      r_bg_meta    <= 1'b1;
      r_bg_s       <= 1'b1;
    end else begin
      r_br_meta    <= BR_MB_n;
      r_br_s       <= r_br_meta;
      r_bgack_meta <= BGACK_MB_n;
      r_bgack_s    <= r_bgack_meta;
      r_bg_meta    <= BG_CPU_n;
      r_bg_s       <= r_bg_meta;
    end
  end

  // Outputs are updated on the same edge as the state change, so the
  // output value always matches the state being entered.
  always_ff @(posedge C7M) begin
    if (!RESET_n) begin
      r_state    <= S_IDLE;
      BR_CPU_n   <= 1'b1;
      BG_MB_n    <= 1'b1;
      CPU_OWNER  <= 1'b1;
      DMA_ACTIVE <= 1'b0;
`ifdef ARB_GRANT_TIMEOUT_EN
      r_grant_cnt <= 4'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_br_s && !r_bgack_s) begin
            // A foreign master already holds the bus. Take it over
            // directly, without ever asking the CPU.
            r_state    <= S_DMA;
            CPU_OWNER  <= 1'b0;
            DMA_ACTIVE <= 1'b1;
          end else if (!r_br_s) begin
            r_state  <= S_REQ;
            BR_CPU_n <= 1'b0;
          end
        end

        S_REQ: begin
          if (r_br_s) begin
            r_state  <= S_IDLE;
            BR_CPU_n <= 1'b1;
          end else if (!r_bg_s) begin
            r_state <= S_GRANT;
            BG_MB_n <= 1'b0;
`ifdef ARB_GRANT_TIMEOUT_EN
            r_grant_cnt <= 4'd0;
`endif
          end
        end

        S_GRANT: begin
          // AS_CPU_n must be high as well, so a CPU cycle that is still
          // running completes before ownership changes.
          if (!r_bgack_s && AS_CPU_n) begin
            r_state    <= S_DMA;
            BR_CPU_n   <= 1'b1;
            BG_MB_n    <= 1'b1;
            CPU_OWNER  <= 1'b0;
            DMA_ACTIVE <= 1'b1;
          end else if (r_br_s && r_bgack_s) begin
            r_state  <= S_IDLE;
            BR_CPU_n <= 1'b1;
            BG_MB_n  <= 1'b1;
          end
`ifdef ARB_GRANT_TIMEOUT_EN
          else if (r_grant_cnt == 4'd15 && r_bgack_s) begin
            r_state  <= S_BACKOFF;
            BR_CPU_n <= 1'b1;
            BG_MB_n  <= 1'b1;
          end else if (r_grant_cnt != 4'd15) begin
            r_grant_cnt <= r_grant_cnt + 4'd1;
          end
`endif
        end

        S_DMA: begin
          if (r_bgack_s) begin
            r_state    <= S_RELEASE;
            CPU_OWNER  <= 1'b1;
            DMA_ACTIVE <= 1'b0;
          end
        end

        S_RELEASE: begin
          r_state <= S_IDLE;
        end

        S_BACKOFF: begin
          if (r_br_s) r_state <= S_IDLE;
        end

        default: begin
          r_state    <= S_IDLE;
          BR_CPU_n   <= 1'b1;
          BG_MB_n    <= 1'b1;
          CPU_OWNER  <= 1'b1;
          DMA_ACTIVE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter.
// Expected output vectors are written as {BR_CPU_n, BG_MB_n, CPU_OWNER, DMA_ACTIVE}.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at that
// same point. A change on a synchronised input therefore reaches the outputs
// after the third edge.
module tb_bus_arbiter;

  logic C7M;
  logic RESET_n;
  logic BR_MB_n;
  logic BGACK_MB_n;
  logic BG_CPU_n;
  logic AS_CPU_n;
  logic BR_CPU_n;
  logic BG_MB_n;
  logic CPU_OWNER;
  logic DMA_ACTIVE;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [3:0] O_IDLE  = 4'b1110;
  localparam logic [3:0] O_REQ   = 4'b0110;
  localparam logic [3:0] O_GRANT = 4'b0010;
  localparam logic [3:0] O_DMA   = 4'b1101;

  bus_arbiter dut (
    .C7M        (C7M),
    .RESET_n    (RESET_n),
    .BR_MB_n    (BR_MB_n),
    .BGACK_MB_n (BGACK_MB_n),
    .BG_CPU_n   (BG_CPU_n),
    .AS_CPU_n   (AS_CPU_n),
    .BR_CPU_n   (BR_CPU_n),
    .BG_MB_n    (BG_MB_n),
    .CPU_OWNER  (CPU_OWNER),
    .DMA_ACTIVE (DMA_ACTIVE)
  );

  initial C7M = 1'b0;
  always #5 C7M = ~C7M;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {BR_CPU_n, BG_MB_n, CPU_OWNER, DMA_ACTIVE};
  endfunction

  // Advance n cycles. After every edge, also check the ownership invariants.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge C7M);
      #1;
      chk("owner_xor_dma", {3'b000, CPU_OWNER}, {3'b000, ~DMA_ACTIVE});
      chk("no_br_in_dma", {3'b000, BR_CPU_n | ~DMA_ACTIVE}, 4'b0001);
    end
  endtask

  initial begin
    RESET_n    = 1'b0;
    BR_MB_n    = 1'b1;
    BGACK_MB_n = 1'b1;
    BG_CPU_n   = 1'b1;
    AS_CPU_n   = 1'b1;
    tick(3);
    chk("in_reset", outs(), O_IDLE);
    RESET_n = 1'b1;
    tick(1);
    chk("after_reset", outs(), O_IDLE);

    // Request, then grant.
    BR_MB_n = 1'b0;
    tick(1); chk("req_c1", outs(), O_IDLE);
    tick(1); chk("req_c2", outs(), O_IDLE);
    tick(1); chk("req_c3", outs(), O_REQ);
    BG_CPU_n = 1'b0;
    tick(2); chk("grant_c2", outs(), O_REQ);
    tick(1); chk("grant_c3", outs(), O_GRANT);

    // BGACK arrives while the CPU cycle is still running.
    AS_CPU_n   = 1'b0;
    BGACK_MB_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1); chk("hold_as_low", outs(), O_GRANT);
    end
    AS_CPU_n = 1'b1;
    tick(1); chk("enter_dma", outs(), O_DMA);

    // Changes on BR are ignored during DMA.
    BR_MB_n  = 1'b1;
    BG_CPU_n = 1'b1;
    tick(4); chk("dma_ignore_br", outs(), O_DMA);

    // Release with a re-request already pending.
    BR_MB_n    = 1'b0;
    BGACK_MB_n = 1'b1;
    tick(2); chk("rel_c2", outs(), O_DMA);
    tick(1); chk("release_cycle", outs(), O_IDLE);
    tick(1); chk("idle_after_rel", outs(), O_IDLE);
    tick(1); chk("rerequest", outs(), O_REQ);

    // Request withdrawn from REQ.
    BR_MB_n = 1'b1;
    tick(2); chk("wd_c2", outs(), O_REQ);
    tick(1); chk("wd_c3", outs(), O_IDLE);

    // Short request pulse that drops before any bus grant.
    BR_MB_n = 1'b0;
    tick(2); chk("pulse_c2", outs(), O_IDLE);
    tick(1); chk("pulse_c3", outs(), O_REQ);
    BR_MB_n = 1'b1;
    tick(2); chk("pulse_c5", outs(), O_REQ);
    tick(1); chk("pulse_drop", outs(), O_IDLE);
    for (int i = 0; i < 3; i++) begin
      tick(1); chk("pulse_no_bg", outs(), O_IDLE);
    end

    // A foreign master already owns the bus: go directly to DMA.
    BR_MB_n    = 1'b0;
    BGACK_MB_n = 1'b0;
    tick(1); chk("direct_c1", outs(), O_IDLE);
    tick(1); chk("direct_c2", outs(), O_IDLE);
    tick(1); chk("direct_dma", outs(), O_DMA);

    // Reset pulse during DMA, with BGACK still asserted.
    RESET_n = 1'b0;
    tick(1); chk("reset_in_dma", outs(), O_IDLE);
    RESET_n    = 1'b1;
    BR_MB_n    = 1'b1;
    BGACK_MB_n = 1'b1;
    tick(4); chk("post_reset_idle", outs(), O_IDLE);

    // Grant that is never acknowledged.
    BR_MB_n  = 1'b0;
    BG_CPU_n = 1'b0;
    tick(3); chk("to_c3", outs(), O_REQ);
    tick(1); chk("to_grant", outs(), O_GRANT);
`ifdef ARB_GRANT_TIMEOUT_EN
    tick(15); chk("to_last_grant", outs(), O_GRANT);
    tick(1);  chk("to_backoff", outs(), O_IDLE);
    tick(5);  chk("to_no_rereq", outs(), O_IDLE);
    BR_MB_n = 1'b1;
    tick(3);  chk("to_br_high", outs(), O_IDLE);
    BR_MB_n = 1'b0;
    tick(2);  chk("to_rr_c2", outs(), O_IDLE);
    tick(1);  chk("to_rereq", outs(), O_REQ);
    tick(1);  chk("to_regrant", outs(), O_GRANT);
`else
    tick(100); chk("grant_100", outs(), O_GRANT);
`endif

    // Both request and BG drop while in GRANT: return to IDLE.
    BR_MB_n  = 1'b1;
    BG_CPU_n = 1'b1;
    tick(2); chk("gdrop_c2", outs(), O_GRANT);
    tick(1); chk("gdrop_idle", outs(), O_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- C7M  input  1  sole clock; all state on rising edge.
- RESET_n  input  1  synchronous active-low reset.
- BR_MB_n  input  1  Zorro II bus request from DMA master (A590/GVP); asynchronous.
- BGACK_MB_n  input  1  bus-grant-acknowledge from DMA master; asynchronous.
- BG_CPU_n  input  1  bus grant from 68000; asynchronous.
- AS_CPU_n  input  1  CPU address strobe.
- BR_CPU_n  output  1  bus request to 68000.
- BG_MB_n  output  1  bus grant to DMA master.
- CPU_OWNER  output  1  high while CPU owns the bus; top level drives AS_MB_n only when high.
- DMA_ACTIVE  output  1  high while DMA master owns the bus; gates fast_dtack and speed-switch sampling.

Function
REQ-002 The block SHALL pass BR_MB_n, BGACK_MB_n and BG_CPU_n through two-flop synchronisers (br_s, bgack_s, bg_s) before any use.
- 2-cycle input latency.
REQ-003 Outputs SHALL all be registered.
REQ-004 States SHALL be: IDLE, REQ, GRANT, DMA, RELEASE, BACKOFF.
REQ-005 IDLE outputs: BR_CPU_n=1, BG_MB_n=1, CPU_OWNER=1, DMA_ACTIVE=0.
- br_s=0 and bgack_s=1 -> REQ; BR_CPU_n=0 from the next cycle.
REQ-006 REQ: BR_CPU_n=0.
- br_s=1 (request withdrawn) -> IDLE; BR_CPU_n=1.
- Otherwise bg_s=0 -> GRANT; BG_MB_n=0.
REQ-007 GRANT: BR_CPU_n=0, BG_MB_n=0.
- bgack_s=0 and AS_CPU_n=1 -> DMA; same edge sets BR_CPU_n=1, BG_MB_n=1, CPU_OWNER=0, DMA_ACTIVE=1.
- bgack_s=0 while AS_CPU_n=0 -> stay in GRANT until AS_CPU_n=1 (CPU cycle must complete).
- br_s=1 and bgack_s=1 -> IDLE.
REQ-008 DMA: CPU_OWNER=0, DMA_ACTIVE=1, BR_CPU_n=1, BG_MB_n=1.
- Exit only on bgack_s=1 -> RELEASE; br_s changes are ignored in DMA.
REQ-009 RELEASE lasts exactly one cycle: CPU_OWNER=1, DMA_ACTIVE=0, then IDLE.
- Guarantees at least one IDLE cycle before re-arbitration.
REQ-010 Simultaneous br_s=0 and bgack_s=0 in IDLE (foreign master already owns the bus) SHALL go directly to DMA without asserting BR_CPU_n.
REQ-011 No request from the arbiter to the CPU SHALL be outstanding (BR_CPU_n=0) while DMA_ACTIVE=1.
REQ-012 CPU_OWNER and DMA_ACTIVE SHALL never both be 1, and never both be 0.
REQ-013 Unused state encodings SHALL recover to IDLE on the next clock.

Reset
REQ-014 With RESET_n=0 at a C7M edge, the block SHALL enter IDLE with BR_CPU_n=1, BG_MB_n=1, CPU_OWNER=1, DMA_ACTIVE=0; synchroniser flops SHALL reset to 1 and the grant counter to 0.
REQ-015 Reset asserted mid-DMA SHALL abort ownership immediately (CPU_OWNER=1 on the first post-reset cycle) regardless of BGACK_MB_n.
REQ-016 After reset release, the block SHALL require br_s=0 observed in IDLE before any new request is made.

Configuration
REQ-017 Macro ARB_GRANT_TIMEOUT_EN SHALL control the grant watchdog.
- Defined: a 4-bit counter clears on entry to GRANT and increments each GRANT cycle.
- If the count reaches 15 with bgack_s=1, next state is BACKOFF; BR_CPU_n=1, BG_MB_n=1.
- BACKOFF behaves as IDLE on outputs and returns to IDLE only after br_s=1.
- Not defined: no counter; GRANT waits indefinitely; BACKOFF unreachable.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Reset, then BR_MB_n=0 with BGACK_MB_n=1 -> BR_CPU_n=0 by cycle 3; BG_CPU_n=0 -> BG_MB_n=0 within 3 cycles.
- In GRANT, BGACK_MB_n=0 while AS_CPU_n=0 for 4 cycles -> stays in GRANT; after AS_CPU_n=1 -> CPU_OWNER=0, DMA_ACTIVE=1, BR_CPU_n=1 within 1 cycle after sync.
- In DMA, BGACK_MB_n=1 -> exactly one RELEASE cycle, then IDLE with CPU_OWNER=1; re-request honoured no earlier than the following cycle.
- BR_MB_n pulsed low 3 cycles, then high before BG_CPU_n -> BR_CPU_n returns to 1; no BG_MB_n pulse.
- With ARB_GRANT_TIMEOUT_EN, grant held 16 cycles with no BGACK -> BR_CPU_n=1, BG_MB_n=1, no re-request until BR_MB_n goes high then low; without the macro, grant held for 100 cycles.
- RESET_n=0 for 1 cycle during DMA -> next cycle CPU_OWNER=1, DMA_ACTIVE=0, BR_CPU_n=1, BG_MB_n=1.
